// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_if
// Brief    : Upstream/downstream valid-ready bundle for the ALU execute stage.
// Revision : 1.0  initial release
// ============================================================================
interface alu_exec_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [4:0]      out_rd;
    logic            out_illegal;

    // master: the ID/EX driver and EX/MEM consumer; slave: the execute stage
    modport master (
        output in_valid, alu_ctrl, op_a, op_b, rd, flush, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, rd, flush, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Brief    : 64-bit execute-stage ALU feeding a 2-entry valid/ready buffer.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
    parameter int XLEN = 64
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_exec_if.slave   bus
);
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic            w_zero;
    logic            w_push;
    logic            w_pop;

    logic [XLEN-1:0] r_res  [2];
    logic [4:0]      r_rd   [2];
    logic [1:0]      r_zero;
    logic [1:0]      r_ill;
    logic [1:0]      r_count;
    logic            r_wptr;
    logic            r_rptr;

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (bus.alu_ctrl)
            c_OP_AND: w_result = bus.op_a & bus.op_b;
            c_OP_OR:  w_result = bus.op_a | bus.op_b;
            c_OP_ADD: w_result = bus.op_a + bus.op_b;
            c_OP_SUB: w_result = bus.op_a - bus.op_b;
            c_OP_SLT: w_result = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            c_OP_NOR: w_result = ~(bus.op_a | bus.op_b);
            default:  w_illegal = 1'b1;
        endcase
    end

    assign w_zero = (w_result == '0);

    // Ready is a function of registered occupancy only, so no combinational
    // path exists from out_ready back to in_ready.
    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid  & bus.in_ready  & ~bus.flush;
    assign w_pop         = bus.out_valid & bus.out_ready & ~bus.flush;

    assign bus.out_result  = r_res[r_rptr];
    assign bus.out_rd      = r_rd[r_rptr];
    assign bus.out_zero    = r_zero[r_rptr];
    assign bus.out_illegal = r_ill[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_zero  <= 2'b00;
            r_ill   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_res[i] <= '0;
                r_rd[i]  <= '0;
            end
        end else if (bus.flush) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_res[r_wptr]  <= w_result;
                r_rd[r_wptr]   <= bus.rd;
                r_zero[r_wptr] <= w_zero;
                r_ill[r_wptr]  <= w_illegal;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Brief    : Vector table plus scoreboard bench for alu_exec_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;
    typedef struct packed {
        logic [63:0] result;
        logic        zero;
        logic        illegal;
        logic [4:0]  rd;
    } exp_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        zero;
        logic        illegal;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   pops;
    int   pushes;
    exp_t sb[$];

    alu_exec_if #(.XLEN(64)) bus ();

    alu_exec_stage #(.XLEN(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Independent reference of the ALU codes.
    function automatic exp_t model(input logic [3:0] c, input logic [63:0] a,
                                   input logic [63:0] b, input logic [4:0] rd);
        exp_t e;
        e.rd      = rd;
        e.illegal = 1'b0;
        case (c)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: e.result = a + b;
            4'b0110: e.result = a + (~b) + 64'd1;
            4'b0111: e.result = (a[63] != b[63]) ? {63'd0, a[63]} : {63'd0, (a < b)};
            4'b1100: e.result = ~a & ~b;
            default: begin e.result = 64'd0; e.illegal = 1'b1; end
        endcase
        e.zero = (e.result == 64'd0);
        return e;
    endfunction

    // One clock: decide handshakes from the settled inputs, score, advance.
    task automatic tick(input exp_t e, output bit pushed);
        bit   push;
        bit   pop;
        exp_t h;
        push = bus.in_valid && bus.in_ready && !bus.flush;
        pop  = bus.out_valid && bus.out_ready && !bus.flush;
        if (pop) begin
            pops++;
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                h = sb.pop_front();
                chk("result", bus.out_result, h.result);
                chk("zero", {63'd0, bus.out_zero}, {63'd0, h.zero});
                chk("illegal", {63'd0, bus.out_illegal}, {63'd0, h.illegal});
                chk("rd", {59'd0, bus.out_rd}, {59'd0, h.rd});
            end
        end
        if (bus.flush) sb.delete();
        if (push) begin
            sb.push_back(e);
            pushes++;
        end
        pushed = push;
        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, (sb.size() != 0)});
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (sb.size() < 2)});
    endtask

    exp_t nop_e;
    bit   acc;
    vec_t vecs[10];

    initial begin
        checks   = 0;
        failures = 0;
        pops     = 0;
        pushes   = 0;
        nop_e    = '0;

        vecs[0] = '{4'b0010, 64'd5, 64'd3, 5'd1, 64'd8, 1'b0, 1'b0};
        vecs[1] = '{4'b0110, 64'd5, 64'd3, 5'd2, 64'd2, 1'b0, 1'b0};
        vecs[2] = '{4'b0000, 64'd5, 64'd3, 5'd3, 64'd1, 1'b0, 1'b0};
        vecs[3] = '{4'b0001, 64'd5, 64'd3, 5'd4, 64'd7, 1'b0, 1'b0};
        vecs[4] = '{4'b0111, 64'd5, 64'd3, 5'd5, 64'd0, 1'b1, 1'b0};
        vecs[5] = '{4'b1100, 64'd5, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0};
        vecs[6] = '{4'b0110, 64'h1234, 64'h1234, 5'd10, 64'd0, 1'b1, 1'b0};
        vecs[7] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd11, 64'd0, 1'b1, 1'b0};
        vecs[8] = '{4'b0111, 64'h8000_0000_0000_0000, 64'd1, 5'd12, 64'd1, 1'b0, 1'b0};
        vecs[9] = '{4'b1111, 64'd5, 64'd3, 5'd7, 64'd0, 1'b1, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'd0;
        bus.op_a      = 64'd0;
        bus.op_b      = 64'd0;
        bus.rd        = 5'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_result", bus.out_result, 64'd0);
        chk("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
        chk("rst_out_zero_ill", {62'd0, bus.out_zero, bus.out_illegal}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single operations, each accepted then consumed the next cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_ctrl = vecs[i].ctrl;
            bus.op_a     = vecs[i].a;
            bus.op_b     = vecs[i].b;
            bus.rd       = vecs[i].rd;
            tick('{vecs[i].result, vecs[i].zero, vecs[i].illegal, vecs[i].rd}, acc);
            chk("accept", {63'd0, acc}, 64'd1);
            bus.in_valid = 1'b0;
            tick(nop_e, acc);
        end

        // Backpressure: rd=1,2 fill the buffer, rd=3 is held off.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_ctrl = 4'b0010;
            bus.op_a     = 64'd100 * i;
            bus.op_b     = 64'd1;
            bus.rd       = 5'(i);
            tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
            if (i == 3) chk("held_off", {63'd0, acc}, 64'd0);
        end
        tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("full_head_rd", {59'd0, bus.out_rd}, 64'd1);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
            if (acc) bus.in_valid = 1'b0;
        end
        chk("bp_rd3_accepted", {63'd0, bus.in_valid}, 64'd0);
        chk("push_pop_balance", 64'(pushes), 64'(pops));

        // Random traffic with payload held until accepted.
        acc = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (acc || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 6))
                    0: bus.alu_ctrl = 4'b0000;
                    1: bus.alu_ctrl = 4'b0001;
                    2: bus.alu_ctrl = 4'b0010;
                    3: bus.alu_ctrl = 4'b0110;
                    4: bus.alu_ctrl = 4'b0111;
                    5: bus.alu_ctrl = 4'b1100;
                    default: bus.alu_ctrl = 4'($urandom_range(0, 15));
                endcase
                bus.op_a = {$urandom, $urandom};
                bus.op_b = ($urandom_range(0, 7) == 0) ? bus.op_a : {$urandom, $urandom};
                bus.rd   = 5'($urandom_range(0, 31));
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) tick(nop_e, acc);
        chk("drained", 64'(sb.size()), 64'd0);

        // Flush with two entries buffered and a simultaneous input.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_ctrl = 4'b0001;
            bus.op_a     = 64'd20 + i;
            bus.op_b     = 64'd0;
            bus.rd       = 5'(20 + i);
            tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
        end
        bus.rd    = 5'd9;
        bus.flush = 1'b1;
        tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
        chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 3; n++) tick(nop_e, acc);

        // Asynchronous reset mid-stream.
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 4'b0010;
        bus.op_a     = 64'd1;
        bus.op_b     = 64'd1;
        bus.rd       = 5'd3;
        bus.out_ready = 1'b0;
        tick(model(bus.alu_ctrl, bus.op_a, bus.op_b, bus.rd), acc);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("async_rst_result", bus.out_result, 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick(nop_e, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
